// File: rtl/traffic_light_timed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_timed_ctrl
// Purpose  : Timed two-road intersection controller. Each phase has its own
//            dwell time, counted in tick_en strobes. The controller runs
//            all-red clearance phases between greens, latches pedestrian
//            requests and serves them with a WALK phase, and supports a
//            night flashing mode.
// Ports    : clk         - system clock
//            rst         - asynchronous, active-high reset
//            tick_en     - timing strobe; timer and state move only when high
//            ped_req     - pedestrian button (level, sampled every clk)
//            flash_mode  - request night flashing mode
//            ns_light    - NS lamps: 00 red, 01 yellow, 10 green, 11 dark
//            ew_light    - EW lamps, same encoding
//            walk        - pedestrian WALK lamp
//            ped_pending - pedestrian request latched and not yet served
//            phase       - current state code (debug)
// Revision : 1.0 - initial release
// ============================================================================
module traffic_light_timed_ctrl #(
    parameter int CNT_W        = 8,
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 4,
    parameter int ALLRED_TICKS = 2,
    parameter int WALK_TICKS   = 10,
    parameter int FLASH_TICKS  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_en,
    input  logic       ped_req,
    input  logic       flash_mode,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_NS_G  = 3'd0,
        S_NS_Y  = 3'd1,
        S_AR1   = 3'd2,
        S_EW_G  = 3'd3,
        S_EW_Y  = 3'd4,
        S_AR2   = 3'd5,
        S_WALK  = 3'd6,
        S_FLASH = 3'd7
    } state_t;

    localparam logic [1:0] C_LAMP_RED    = 2'b00;
    localparam logic [1:0] C_LAMP_YELLOW = 2'b01;
    localparam logic [1:0] C_LAMP_GREEN  = 2'b10;
    localparam logic [1:0] C_LAMP_DARK   = 2'b11;

    // Timer reload values: a phase of N ticks loads N-1 and expires on the
    // tick that finds the timer at zero.
    localparam logic [CNT_W-1:0] C_GREEN_LD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] C_YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] C_ALLRED_LD = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] C_WALK_LD   = CNT_W'(WALK_TICKS - 1);
    localparam logic [CNT_W-1:0] C_FLASH_LD  = CNT_W'(FLASH_TICKS - 1);

    state_t           state_q,       state_d;
    logic [CNT_W-1:0] timer_q,       timer_d;
    logic             flash_on_q,    flash_on_d;
    logic             ped_pending_q, ped_pending_d;

    // ------------------------------------------------------------------
    // Next-state, timer and pedestrian latch
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        flash_on_d = flash_on_q;

        if (tick_en) begin
            if (timer_q == '0) begin
                unique case (state_q)
                    S_NS_G: begin
                        state_d = S_NS_Y;
                        timer_d = C_YELLOW_LD;
                    end
                    S_NS_Y: begin
                        state_d = S_AR1;
                        timer_d = C_ALLRED_LD;
                    end
                    S_AR1: begin
                        state_d = S_EW_G;
                        timer_d = C_GREEN_LD;
                    end
                    S_EW_G: begin
                        state_d = S_EW_Y;
                        timer_d = C_YELLOW_LD;
                    end
                    S_EW_Y: begin
                        state_d = S_AR2;
                        timer_d = C_ALLRED_LD;
                    end
                    S_AR2: begin
                        // Only decision point of the cycle: flashing takes
                        // priority over a waiting pedestrian.
                        if (flash_mode) begin
                            state_d    = S_FLASH;
                            timer_d    = C_FLASH_LD;
                            flash_on_d = 1'b1;
                        end else if (ped_pending_q) begin
                            state_d = S_WALK;
                            timer_d = C_WALK_LD;
                        end else begin
                            state_d = S_NS_G;
                            timer_d = C_GREEN_LD;
                        end
                    end
                    S_WALK: begin
                        state_d = S_NS_G;
                        timer_d = C_GREEN_LD;
                    end
                    S_FLASH: begin
                        // Leave flashing only at the end of a dark half so
                        // the last visible aspect is never cut short.
                        if (!flash_on_q && !flash_mode) begin
                            state_d = S_AR2;
                            timer_d = C_ALLRED_LD;
                        end else begin
                            flash_on_d = ~flash_on_q;
                            timer_d    = C_FLASH_LD;
                        end
                    end
                    default: begin
                        state_d = S_AR2;
                        timer_d = C_ALLRED_LD;
                    end
                endcase
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end

        // Clearing on WALK entry wins over a same-cycle button press;
        // presses inside WALK are ignored.
        ped_pending_d = ped_pending_q;
        if (state_q != S_WALK && state_d == S_WALK) begin
            ped_pending_d = 1'b0;
        end else if (ped_req && state_q != S_WALK) begin
            ped_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_AR2;
            timer_q       <= C_ALLRED_LD;
            flash_on_q    <= 1'b0;
            ped_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            flash_on_q    <= flash_on_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    // ------------------------------------------------------------------
    // Output decode of registered state only
    // ------------------------------------------------------------------
    always_comb begin
        ns_light = C_LAMP_RED;
        ew_light = C_LAMP_RED;
        walk     = 1'b0;
        unique case (state_q)
            S_NS_G:  ns_light = C_LAMP_GREEN;
            S_NS_Y:  ns_light = C_LAMP_YELLOW;
            S_EW_G:  ew_light = C_LAMP_GREEN;
            S_EW_Y:  ew_light = C_LAMP_YELLOW;
            S_WALK:  walk     = 1'b1;
            S_FLASH: begin
                ns_light = flash_on_q ? C_LAMP_YELLOW : C_LAMP_DARK;
                ew_light = flash_on_q ? C_LAMP_YELLOW : C_LAMP_DARK;
            end
            default: begin
                ns_light = C_LAMP_RED;
                ew_light = C_LAMP_RED;
            end
        endcase
    end

    assign ped_pending = ped_pending_q;
    assign phase       = state_q;

endmodule
`default_nettype wire
